// File: rtl/xmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : xmem_pkg
//  Description : Shared state encoding and abort constant for the xmem arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package xmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN0  = 2'd1,
        ST_OWN1  = 2'd2,
        ST_ABORT = 2'd3
    } xmem_state_t;

    // Read data returned to the owner when the watchdog kills an access
    localparam logic [31:0] c_ABORT_DATA = 32'hFFFF_FFFF;

endpackage : xmem_pkg
`default_nettype wire

// File: rtl/xmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : xmem_arbiter
//  Description : Two-master Wishbone B4 classic round-robin arbiter with a
//                per-access watchdog in front of the HyperRAM wrapper.
//  Revision    : 1.0 - initial release
// ============================================================================
module xmem_arbiter
    import xmem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         reset,

    input  logic [2:31]  m0_adr_i,
    input  logic [0:31]  m0_dat_i,
    output logic [0:31]  m0_dat_o,
    input  logic         m0_we_i,
    input  logic [0:3]   m0_sel_i,
    input  logic         m0_stb_i,
    output logic         m0_ack_o,
    input  logic         m0_cyc_i,

    input  logic [2:31]  m1_adr_i,
    input  logic [0:31]  m1_dat_i,
    output logic [0:31]  m1_dat_o,
    input  logic         m1_we_i,
    input  logic [0:3]   m1_sel_i,
    input  logic         m1_stb_i,
    output logic         m1_ack_o,
    input  logic         m1_cyc_i,

    output logic [2:31]  s_adr_o,
    output logic [0:31]  s_dat_o,
    input  logic [0:31]  s_dat_i,
    output logic         s_we_o,
    output logic [0:3]   s_sel_o,
    output logic         s_stb_o,
    input  logic         s_ack_i,
    output logic         s_cyc_o,

    output logic [0:1]   grant,
    output logic         timeout_flag,
    input  logic         timeout_clr,
    output logic [7:0]   timeout_count
);

    localparam int                 c_WD_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_WD_W-1:0] c_WD_MAX = c_WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_WD_W-1:0] c_WD_ONE = c_WD_W'(1);

    xmem_state_t        r_state;
    xmem_state_t        w_state_nxt;
    logic               r_last;          // 0 = m0 was last owner, 1 = m1
    logic               w_last_nxt;
    logic [c_WD_W-1:0]  r_wd_cnt;
    logic               r_timeout_flag;
    logic [7:0]         r_timeout_count;

    logic w_own0;
    logic w_own1;
    logic w_owned;
    logic w_abort;
    logic w_s_stb;
    logic w_wd_hit;
    logic w_wd_fire;

    assign w_own0  = (r_state == ST_OWN0);
    assign w_own1  = (r_state == ST_OWN1);
    assign w_owned = w_own0 | w_own1;
    assign w_abort = (r_state == ST_ABORT);

    // Slave side: control qualified by ownership, data path defaults to m0
    assign s_cyc_o = (w_own0 & m0_cyc_i) | (w_own1 & m1_cyc_i);
    assign w_s_stb = (w_own0 & m0_stb_i) | (w_own1 & m1_stb_i);
    assign s_stb_o = w_s_stb;
    assign s_we_o  = (w_own0 & m0_we_i)  | (w_own1 & m1_we_i);
    assign s_adr_o = w_own1 ? m1_adr_i : m0_adr_i;
    assign s_dat_o = w_own1 ? m1_dat_i : m0_dat_i;
    assign s_sel_o = w_own1 ? m1_sel_i : m0_sel_i;

    // During ABORT, r_last already names the master whose access was killed
    assign m0_ack_o = (w_own0 & s_ack_i) | (w_abort & ~r_last);
    assign m1_ack_o = (w_own1 & s_ack_i) | (w_abort &  r_last);
    assign m0_dat_o = w_own0 ? s_dat_i : ((w_abort & ~r_last) ? c_ABORT_DATA : '0);
    assign m1_dat_o = w_own1 ? s_dat_i : ((w_abort &  r_last) ? c_ABORT_DATA : '0);

    assign grant         = {w_own0, w_own1};
    assign timeout_flag  = r_timeout_flag;
    assign timeout_count = r_timeout_count;

    assign w_wd_hit = w_owned & w_s_stb & ~s_ack_i & (r_wd_cnt == c_WD_MAX);

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_wd_fire   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    w_state_nxt = r_last ? ST_OWN0 : ST_OWN1;
                end else if (m0_cyc_i) begin
                    w_state_nxt = ST_OWN0;
                end else if (m1_cyc_i) begin
                    w_state_nxt = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!m0_cyc_i) begin
                    w_state_nxt = ST_IDLE;
                    w_last_nxt  = 1'b0;
                end else if (w_wd_hit) begin
                    w_state_nxt = ST_ABORT;
                    w_last_nxt  = 1'b0;
                    w_wd_fire   = 1'b1;
                end
            end
            ST_OWN1: begin
                if (!m1_cyc_i) begin
                    w_state_nxt = ST_IDLE;
                    w_last_nxt  = 1'b1;
                end else if (w_wd_hit) begin
                    w_state_nxt = ST_ABORT;
                    w_last_nxt  = 1'b1;
                    w_wd_fire   = 1'b1;
                end
            end
            ST_ABORT: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_last          <= 1'b1;
            r_wd_cnt        <= '0;
            r_timeout_flag  <= 1'b0;
            r_timeout_count <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;

            if (w_owned && (w_state_nxt == r_state) && w_s_stb && !s_ack_i) begin
                r_wd_cnt <= r_wd_cnt + c_WD_ONE;
            end else begin
                r_wd_cnt <= '0;
            end

            // A watchdog event in the same cycle as a clear keeps the flag set
            if (w_wd_fire) begin
                r_timeout_flag <= 1'b1;
            end else if (timeout_clr) begin
                r_timeout_flag <= 1'b0;
            end

            if (w_wd_fire && (r_timeout_count != 8'hFF)) begin
                r_timeout_count <= r_timeout_count + 8'd1;
            end
        end
    end

endmodule : xmem_arbiter
`default_nettype wire
